tqv_periph_fabric: RTL and testbench

Parametrised peripheral interconnect for the TinyQV core. It decodes the 11-bit peripheral address into N_USER full-interface slots and N_SIMPLE byte slots, and runs a registered read-response FSM with a timeout and a sticky error flag. It also hosts the built-in GPIO/config register slot, muxes peripheral outputs onto N_PINS output pins, and gates user interrupts. It sits between the core data port and the peripheral instances.

---
 rtl/tqv_periph_fabric.sv | 210 +++++++++++++++++++++
 tb/tb_tqv_periph_fabric.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tqv_periph_fabric.sv
// Peripheral interconnect for TinyQV: address decode, read-response FSM, GPIO/config slot, pin mux, IRQ gating.
// Optional build macro: PERIPH_FABRIC_IRQ_MASK_EN adds the irq_en register and a registered interrupt mask.
module tqv_periph_fabric #(
    parameter int N_USER         = 16,
    parameter int N_SIMPLE       = 16,
    parameter int N_PINS         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 ui_in,
    output logic [N_PINS-1:0]          uo_out,
    input  logic [10:0]                addr_in,
    input  logic [31:0]                data_in,
    input  logic [1:0]                 data_write_n,
    input  logic [1:0]                 data_read_n,
    input  logic                       data_read_complete,
    output logic [31:0]                data_out,
    output logic                       data_ready,
    output logic [N_USER-1:0]          peri_sel_user,
    output logic [N_SIMPLE-1:0]        peri_sel_simple,
    output logic [1:0]                 peri_write_n,
    output logic [1:0]                 peri_read_n,
    input  logic [32*N_USER-1:0]       user_data_flat,
    input  logic [N_USER-1:0]          user_ready,
    input  logic [8*N_SIMPLE-1:0]      simple_data_flat,
    input  logic [N_PINS*N_USER-1:0]   user_uo_flat,
    input  logic [N_PINS*N_SIMPLE-1:0] simple_uo_flat,
    input  logic [N_USER-1:0]          user_irq_in,
    output logic [N_USER-1:0]          irq_out
);
    // state | meaning
    // IDLE  | accepting read requests
    // WAIT  | selected slot not ready yet, counting towards timeout
    // HOLD  | response latched on data_out until the core consumes it
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              rdy_q, rdy_d;
    logic [N_PINS-1:0] gpio_out_q;
    logic              err_q, err_d, err_set;
    logic [4:0]        func_sel_q [N_PINS];

    logic        slot_valid, slot_ready, int_sel;
    logic [31:0] slot_data, int_rdata;
    logic [5:0]  off;
    logic        rd_req, int_wr;

    assign off    = addr_in[5:0];
    assign rd_req = (data_read_n != 2'b11);
    assign int_wr = int_sel && (data_write_n != 2'b11);

    always_comb begin
        peri_sel_user   = '0;
        peri_sel_simple = '0;
        slot_valid      = 1'b0;
        slot_ready      = 1'b1;
        slot_data       = 32'h0;
        int_sel         = 1'b0;
        if (addr_in[10]) begin
            for (int k = 0; k < N_SIMPLE; k++) begin
                if (addr_in[7:4] == 4'(k)) begin
                    peri_sel_simple[k] = 1'b1;
                    slot_valid         = 1'b1;
                    slot_data          = {24'h0, simple_data_flat[8*k +: 8]};
                end
            end
        end else begin
            for (int k = 0; k < N_USER; k++) begin
                if (addr_in[9:6] == 4'(k)) begin
                    slot_valid = 1'b1;
                    if (k == 1) begin
                        int_sel   = 1'b1;
                        slot_data = int_rdata;
                    end else begin
                        peri_sel_user[k] = 1'b1;
                        slot_ready       = user_ready[k];
                        slot_data        = user_data_flat[32*k +: 32];
                    end
                end
            end
        end
    end

    // The internal slot is served here, so it never appears on the external strobes.
    assign peri_write_n = (slot_valid && !int_sel) ? data_write_n : 2'b11;
    assign peri_read_n  = (state_q == S_IDLE && slot_valid && !int_sel) ? data_read_n : 2'b11;

`ifdef PERIPH_FABRIC_IRQ_MASK_EN
    logic [N_USER-1:0] irq_en_q, irq_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en_q <= '1;
            irq_q    <= '0;
        end else begin
            if (int_wr && off == 6'h0C) irq_en_q <= data_in[N_USER-1:0];
            irq_q <= user_irq_in & irq_en_q;
        end
    end
    assign irq_out = irq_q;
`else
    assign irq_out = user_irq_in;
`endif

    always_comb begin
        int_rdata = 32'h0;
        if (off[1:0] == 2'b00) begin
            case (off[5:2])
                4'h0: int_rdata = 32'(gpio_out_q);
                4'h1: int_rdata = {24'h0, ui_in};
                4'h2: int_rdata = {31'h0, err_q};
`ifdef PERIPH_FABRIC_IRQ_MASK_EN
                4'h3: int_rdata = 32'(irq_en_q);
`endif
                default: begin
                    for (int i = 0; i < N_PINS; i++)
                        if (off[5] && off[4:2] == 3'(i)) int_rdata = {27'h0, func_sel_q[i]};
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        rdy_d      = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            S_IDLE: if (rd_req) begin
                if (slot_ready) begin
                    state_d    = S_HOLD;
                    data_out_d = slot_data;
                    rdy_d      = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 8'h0;
                end
            end
            S_WAIT: begin
                if (!rd_req) begin
                    state_d = S_IDLE;
                end else if (slot_ready) begin
                    state_d    = S_HOLD;
                    data_out_d = slot_data;
                    rdy_d      = 1'b1;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    // Fires on the TIMEOUT_CYCLES-th cycle spent in WAIT.
                    state_d    = S_HOLD;
                    data_out_d = 32'hFFFF_FFFF;
                    rdy_d      = 1'b1;
                    err_set    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            S_HOLD: if (data_read_complete) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign err_d = err_set | (err_q & ~(int_wr && off == 6'h08 && data_in[0]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'h0;
            data_out_q <= 32'h0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            gpio_out_q <= '0;
            for (int i = 0; i < N_PINS; i++) func_sel_q[i] <= (i < 2) ? 5'd2 : 5'd1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            if (int_wr && off == 6'h00) gpio_out_q <= data_in[N_PINS-1:0];
            for (int i = 0; i < N_PINS; i++)
                if (int_wr && off[5] && off[1:0] == 2'b00 && off[4:2] == 3'(i))
                    func_sel_q[i] <= data_in[4:0];
        end
    end

    assign data_out   = data_out_q;
    assign data_ready = rdy_q | (data_write_n != 2'b11);

    always_comb begin
        uo_out = '0;
        for (int i = 0; i < N_PINS; i++) begin
            if (func_sel_q[i][4]) begin
                for (int k = 0; k < N_SIMPLE; k++)
                    if (func_sel_q[i][3:0] == 4'(k)) uo_out[i] = simple_uo_flat[N_PINS*k + i];
            end else if (func_sel_q[i][3:0] == 4'd1) begin
                uo_out[i] = gpio_out_q[i];
            end else begin
                for (int k = 0; k < N_USER; k++)
                    if (k != 1 && func_sel_q[i][3:0] == 4'(k)) uo_out[i] = user_uo_flat[N_PINS*k + i];
            end
        end
    end

    // Slot 1 is internal, so its external inputs are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{data_in[31:8], addr_in[8], user_ready[1],
                           user_data_flat[63:32], user_uo_flat[2*N_PINS-1:N_PINS]};
endmodule

// File: tb/tb_tqv_periph_fabric.sv
// Directed bench for tqv_periph_fabric (TIMEOUT_CYCLES=8); expected values hand-computed.
module tb_tqv_periph_fabric;
    localparam int NU = 16;
    localparam int NS = 16;
    localparam int NP = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      ui_in;
    logic [NP-1:0]   uo_out;
    logic [10:0]     addr_in;
    logic [31:0]     data_in;
    logic [1:0]      data_write_n;
    logic [1:0]      data_read_n;
    logic            data_read_complete;
    logic [31:0]     data_out;
    logic            data_ready;
    logic [NU-1:0]   peri_sel_user;
    logic [NS-1:0]   peri_sel_simple;
    logic [1:0]      peri_write_n;
    logic [1:0]      peri_read_n;
    logic [32*NU-1:0] user_data_flat;
    logic [NU-1:0]   user_ready;
    logic [8*NS-1:0] simple_data_flat;
    logic [NP*NU-1:0] user_uo_flat;
    logic [NP*NS-1:0] simple_uo_flat;
    logic [NU-1:0]   user_irq_in;
    logic [NU-1:0]   irq_out;

    int n_checks = 0;
    int n_pass   = 0;

    tqv_periph_fabric #(.N_USER(NU), .N_SIMPLE(NS), .N_PINS(NP), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .addr_in(addr_in), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_read_complete(data_read_complete),
        .data_out(data_out), .data_ready(data_ready),
        .peri_sel_user(peri_sel_user), .peri_sel_simple(peri_sel_simple),
        .peri_write_n(peri_write_n), .peri_read_n(peri_read_n),
        .user_data_flat(user_data_flat), .user_ready(user_ready),
        .simple_data_flat(simple_data_flat), .user_uo_flat(user_uo_flat),
        .simple_uo_flat(simple_uo_flat), .user_irq_in(user_irq_in), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        addr_in = a; data_in = d; data_write_n = 2'b10;
        step();
        data_write_n = 2'b11;
    endtask

    task automatic rd(input string tag, input logic [10:0] a, input logic [31:0] exp);
        int c;
        addr_in = a; data_read_n = 2'b10;
        c = 0;
        step();
        while (!data_ready && c < 20) begin
            step();
            c++;
        end
        check({tag, "_rdy"}, {31'h0, data_ready}, 32'h1);
        check(tag, data_out, exp);
        data_read_n = 2'b11; data_read_complete = 1'b1;
        step();
        data_read_complete = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ui_in = 8'h00; addr_in = '0; data_in = '0;
        data_write_n = 2'b11; data_read_n = 2'b11; data_read_complete = 1'b0;
        user_data_flat = '0; user_ready = '0; simple_data_flat = '0;
        user_uo_flat = '0; simple_uo_flat = '0; user_irq_in = '0;
        step(); step();
        check("rst_data_out", data_out, 32'h0);
        check("rst_data_ready", {31'h0, data_ready}, 32'h0);
        check("rst_uo", {24'h0, uo_out}, 32'h0);
        rst_n = 1'b1;
        step();

        // GPIO write and readback
        addr_in = 11'h040; data_in = 32'hA5; data_write_n = 2'b10;
        #1;
        check("wr_ready_comb", {31'h0, data_ready}, 32'h1);
        check("wr_int_no_strobe", {30'h0, peri_write_n}, 32'h3);
        step();
        data_write_n = 2'b11;
        #1;
        check("uo_gpio", {24'h0, uo_out}, 32'hA4);
        user_uo_flat[NP*2 +: NP] = 8'h03;
        #1;
        check("uo_uart_pins", {24'h0, uo_out}, 32'hA7);
        rd("rd_gpio", 11'h040, 32'hA5);

        // simple slot 2
        simple_data_flat[8*2 +: 8] = 8'h5C;
        addr_in = 11'h420; data_read_n = 2'b10;
        #1;
        check("simple_sel", {16'h0, peri_sel_simple}, 32'h0004);
        check("simple_rd_n", {30'h0, peri_read_n}, 32'h2);
        step();
        check("simple_rdy_lat1", {31'h0, data_ready}, 32'h1);
        check("simple_data", data_out, 32'h5C);
        data_read_n = 2'b11; data_read_complete = 1'b1;
        step();
        data_read_complete = 1'b0;
        check("simple_rdy_pulse", {31'h0, data_ready}, 32'h0);

        // user slot 16-bit write forwarded
        addr_in = 11'h100; data_write_n = 2'b01;
        #1;
        check("user_wr_n", {30'h0, peri_write_n}, 32'h1);
        check("user_wr_sel", {16'h0, peri_sel_user}, 32'h0010);
        data_write_n = 2'b11;

        // slot 4, ready after 5 cycles
        user_data_flat[32*4 +: 32] = 32'h1234_5678;
        data_read_n = 2'b10;
        #1;
        check("s4_rd_n_c0", {30'h0, peri_read_n}, 32'h2);
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("s4_wait_c%0d", c), {29'h0, data_ready, peri_read_n}, 32'h3);
        end
        user_ready[4] = 1'b1;
        step();
        check("s4_rdy_c6", {31'h0, data_ready}, 32'h1);
        check("s4_data", data_out, 32'h1234_5678);
        user_ready[4] = 1'b0; user_data_flat[32*4 +: 32] = 32'hDEAD_BEEF; data_read_n = 2'b11;
        step();
        check("s4_hold_rdy", {31'h0, data_ready}, 32'h0);
        check("s4_hold_data", data_out, 32'h1234_5678);
        data_read_complete = 1'b1;
        step();
        data_read_complete = 1'b0;

        // slot 5 timeout
        addr_in = 11'h140; data_read_n = 2'b10;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("to_wait_c%0d", c), {31'h0, data_ready}, 32'h0);
        end
        step();
        check("to_rdy_c9", {31'h0, data_ready}, 32'h1);
        check("to_data", data_out, 32'hFFFF_FFFF);
        data_read_n = 2'b11; data_read_complete = 1'b1;
        step();
        data_read_complete = 1'b0;
        rd("status_set", 11'h048, 32'h1);
        wr(11'h048, 32'h1);
        rd("status_clr", 11'h048, 32'h0);

        // func_sel[3] -> simple slot 2
        wr(11'h06C, 32'h12);
        simple_uo_flat[NP*2 + 3] = 1'b1;
        #1;
        check("uo_simple_on", {24'h0, uo_out}, 32'hAF);
        simple_uo_flat[NP*2 + 3] = 1'b0;
        #1;
        check("uo_simple_off", {24'h0, uo_out}, 32'hA7);
        rd("rd_func_sel3", 11'h06C, 32'h12);

        // reset during WAIT
        addr_in = 11'h140; data_read_n = 2'b10;
        step(); step();
        rst_n = 1'b0;
        step();
        check("rst_wait_rdy", {31'h0, data_ready}, 32'h0);
        rst_n = 1'b1; data_read_n = 2'b11;
        step();
        check("post_rst_rdy", {31'h0, data_ready}, 32'h0);
        check("post_rst_uo", {24'h0, uo_out}, 32'h03);
        ui_in = 8'h3C;
        rd("rd_ui_in", 11'h044, 32'h3C);

`ifdef PERIPH_FABRIC_IRQ_MASK_EN
        wr(11'h04C, 32'h0010);
        user_irq_in = 16'h0030;
        #1;
        check("irq_before_edge", {16'h0, irq_out}, 32'h0);
        step();
        check("irq_masked", {16'h0, irq_out}, 32'h0010);
`else
        user_irq_in = 16'h0030;
        #1;
        check("irq_comb", {16'h0, irq_out}, 32'h0030);
        wr(11'h04C, 32'h0010);
        rd("irq_en_absent", 11'h04C, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
